// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the selects, samples y after a dwell, and hands the 4-bit word out via valid/ready.
// Optional MUX_SCAN_PARITY_EN adds a registered parity_out over the assembled word.
module mux_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y_in,
  output logic       sel2,
  output logic       sel1,
  output logic [3:0] data_out,
  output logic       valid,
  input  logic       ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic       busy,
  output logic       parity_out
`else
  output logic       busy
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             parity_q, parity_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 2'b00;
      cnt_q    <= '0;
      shadow_q <= 4'b0000;
      data_q   <= 4'b0000;
      valid_q  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    parity_d = parity_q;
    case (state_q)
      IDLE: begin
        sel_d = 2'b00;
        if (start) begin
          state_d  = SCAN;
          cnt_d    = '0;
          shadow_d = 4'b0000;
        end
      end
      SCAN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Select code s reads i[3-s], so its sample lands in shadow bit 3-s.
          cnt_d = '0;
          shadow_d[2'd3 - sel_q] = y_in;
          if (sel_q != 2'b11) begin
            sel_d = sel_q + 2'b01;
          end else begin
            data_d   = {shadow_q[3:1], y_in};
            parity_d = ^{shadow_q[3:1], y_in};
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          sel_d   = 2'b00;
          if (cont) begin
            state_d  = SCAN;
            cnt_d    = '0;
            shadow_d = 4'b0000;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'b00;
        valid_d = 1'b0;
      end
    endcase
  end

  assign sel2     = sel_q[1];
  assign sel1     = sel_q[0];
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = (state_q != IDLE);

`ifdef MUX_SCAN_PARITY_EN
  assign parity_out = parity_q;
`else
  logic unusedParity;
  assign unusedParity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (DWELL=2 and DWELL=1), each feeding a behavioural 4:1 mux back into y_in.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DWELL=2
  logic       startA, contA, readyA, yA, selA2, selA1, validA, busyA;
  logic [3:0] iA, dataA;
  // Instance B: DWELL=1
  logic       startB, contB, readyB, yB, selB2, selB1, validB, busyB;
  logic [3:0] iB, dataB;
`ifdef MUX_SCAN_PARITY_EN
  logic       parityA, parityB;
`endif

  // Behavioural 4:1 mux: select 00 picks i[3] ... 11 picks i[0].
  assign yA = iA[2'd3 - {selA2, selA1}];
  assign yB = iB[2'd3 - {selB2, selB1}];

  mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .cont(contA), .y_in(yA),
    .sel2(selA2), .sel1(selA1), .data_out(dataA), .valid(validA),
    .ready(readyA),
`ifdef MUX_SCAN_PARITY_EN
    .busy(busyA), .parity_out(parityA)
`else
    .busy(busyA)
`endif
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .cont(contB), .y_in(yB),
    .sel2(selB2), .sel1(selB1), .data_out(dataB), .valid(validB),
    .ready(readyB),
`ifdef MUX_SCAN_PARITY_EN
    .busy(busyB), .parity_out(parityB)
`else
    .busy(busyB)
`endif
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-edge start pulse on the selected instance.
  task automatic applyStimulus(input bit onB);
    if (onB) startB = 1'b1; else startA = 1'b1;
    tick();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    startA = 0; contA = 0; readyA = 0; iA = 4'b0000;
    startB = 0; contB = 0; readyB = 0; iB = 4'b0000;
    #3;
    checkOutput("rst_selA", {selA2, selA1}, 8'h0);
    checkOutput("rst_validA", validA, 8'h0);
    checkOutput("rst_busyA", busyA, 8'h0);
    checkOutput("rst_dataA", dataA, 8'h0);
    checkOutput("rst_validB", validB, 8'h0);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("rst_parityA", parityA, 8'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] DWELL=2 single scan, i=0101");
    iA = 4'b0101; readyA = 1'b1;
    applyStimulus(1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("seqA_sel%0d", k), {selA2, selA1}, 8'(k / 2));
      checkOutput($sformatf("seqA_valid%0d", k), validA, 8'h0);
      tick();
    end
    checkOutput("w1_valid", validA, 8'h1);
    checkOutput("w1_data", dataA, 8'h5);
    checkOutput("w1_busy", busyA, 8'h1);
    tick();
    checkOutput("w1_hs_valid", validA, 8'h0);
    checkOutput("w1_hs_busy", busyA, 8'h0);
    checkOutput("w1_hs_data", dataA, 8'h5);

    $display("[TB] DWELL=1 scan, i=1001, ready held low");
    iB = 4'b1001; readyB = 1'b0;
    applyStimulus(1'b1);
    tick(); tick(); tick();
    checkOutput("B_valid_early", validB, 8'h0);
    tick();
    checkOutput("B_valid", validB, 8'h1);
    checkOutput("B_data", dataB, 8'h9);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("B_hold_data%0d", k), dataB, 8'h9);
      checkOutput($sformatf("B_hold_valid%0d", k), validB, 8'h1);
    end
    readyB = 1'b1;
    tick();
    checkOutput("B_hs_valid", validB, 8'h0);
    checkOutput("B_hs_busy", busyB, 8'h0);
    readyB = 1'b0;

    $display("[TB] continuous mode with input change mid-scan");
    iA = 4'b1111; contA = 1'b1; readyA = 1'b1;
    applyStimulus(1'b0);
    for (int k = 0; k < 7; k++) tick();
    checkOutput("c1_valid_early", validA, 8'h0);
    tick();
    checkOutput("c1_valid", validA, 8'h1);
    checkOutput("c1_data", dataA, 8'hF);
    tick();
    checkOutput("c1_hs_valid", validA, 8'h0);
    checkOutput("c1_restart_busy", busyA, 8'h1);
    tick(); tick(); tick();
    iA = 4'b0010; contA = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("c2_wait%0d", k), validA, 8'h0);
    end
    tick();
    checkOutput("c2_valid", validA, 8'h1);
    checkOutput("c2_data", dataA, 8'hA);
    tick();
    checkOutput("c2_hs_busy", busyA, 8'h0);

    $display("[TB] start held high through SCAN and HOLD");
    iA = 4'b0011; readyA = 1'b0; startA = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("st_sel%0d", k), {selA2, selA1}, 8'(k / 2));
    end
    tick();
    checkOutput("st_valid", validA, 8'h1);
    checkOutput("st_data", dataA, 8'h3);
    tick(); tick();
    checkOutput("st_hold_sel", {selA2, selA1}, 8'h3);
    checkOutput("st_hold_valid", validA, 8'h1);
    readyA = 1'b1;
    tick();
    checkOutput("st_hs_busy", busyA, 8'h0);
    startA = 1'b0;
    tick();
    checkOutput("st_noqueue_busy", busyA, 8'h0);
    checkOutput("st_noqueue_valid", validA, 8'h0);

    $display("[TB] reset mid-scan then fresh scan");
    iA = 4'b0110; readyA = 1'b1;
    applyStimulus(1'b0);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("rs_sel_before", {selA2, selA1}, 8'h2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_sel", {selA2, selA1}, 8'h0);
    checkOutput("rs_busy", busyA, 8'h0);
    checkOutput("rs_valid", validA, 8'h0);
    checkOutput("rs_data", dataA, 8'h0);
    #1;
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0);
    for (int k = 0; k < 8; k++) tick();
    checkOutput("rs_new_valid", validA, 8'h1);
    checkOutput("rs_new_data", dataA, 8'h6);
    tick();

    $display("[TB] parity words on DWELL=1 instance");
    iB = 4'b0111; readyB = 1'b0;
    applyStimulus(1'b1);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("p1_data", dataB, 8'h7);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("p1_parity", parityB, 8'h1);
`endif
    readyB = 1'b1;
    tick();
    readyB = 1'b0;
    iB = 4'b0110;
    applyStimulus(1'b1);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("p2_data", dataB, 8'h6);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("p2_parity", parityB, 8'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencing controller that sits directly upstream and downstream of the 4:1 behavioural mux (`i[3:0]`, `sel2`, `sel1` -> `y`).
- Drives `sel2`/`sel1` through all four channels, holding each for a programmable dwell so the mux output settles, then samples `y`.
- Assembles the four samples into a 4-bit word and presents it to a consumer with a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
- DWELL, default 2: clock cycles each select code is held before `y` is sampled; legal range 1..2**CNT_W.
- CNT_W, default 4: width of the dwell counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at each completed handshake.
- y_in  input  1  mux output `y`.
- sel2  output  1  mux select MSB.
- sel1  output  1  mux select LSB.
- data_out  output  4  assembled word; bit k = sample taken while the mux selected i[k].
- valid  output  1  data_out holds a complete word.
- ready  input  1  consumer accepts data_out when valid=1.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, {sel2,sel1}=2'b00, counter=0, shadow=0, data_out=4'b0000, valid=0, busy=0.
- Channel mapping of the mux: {sel2,sel1}=00->i[3], 01->i[2], 10->i[1], 11->i[0]. A sample taken with select code s is stored in shadow bit (3-s).
- FSM states: IDLE, SCAN, HOLD.
- IDLE: outputs sel=00. On an edge with start=1: go to SCAN, sel=00, counter=0.
- SCAN, each edge:
  - counter != DWELL-1: counter+1.
  - counter == DWELL-1: shadow[3-sel] <= y_in, counter <= 0.
    - sel != 11: sel+1.
    - sel == 11: data_out <= shadow with the final sample merged into bit 0; valid <= 1; state <= HOLD; sel stays 11.
- Latency: valid rises exactly 4*DWELL rising edges after the edge that accepted start. DWELL=1 gives one sample per cycle, valid at +4.
- HOLD:
  - data_out and valid held stable until valid&&ready.
  - On the handshake edge: valid <= 0.
    - cont=1: go to SCAN, sel=00, counter=0, shadow cleared. The next word's valid rises 4*DWELL edges later.
    - cont=0: go to IDLE, sel=00.
- Handshake: ready may be high before valid; a transfer occurs only on an edge with valid=1 and ready=1. ready while valid=0 is ignored.
- data_out changes only on the edge that sets valid. It is never modified while valid=1 and is never cleared by a handshake.
- Boundary conditions:
  - start while busy=1 is ignored, with no queuing.
  - start=1 on the HOLD->IDLE handshake edge is not seen; start is honoured from IDLE on the next edge.
  - cont changes during SCAN have no effect until the next handshake.
  - Reset asserted mid-scan or in HOLD aborts immediately. The partial shadow is discarded and all outputs return to reset values asynchronously.
- Counter: CNT_W bits, compare against DWELL-1, never wraps within a legal configuration.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- When defined: extra output `parity_out`, 1 bit, = XOR of the four sampled bits. It is registered on the same edge as data_out, held with it, and reset to 0.
- When undefined: no `parity_out` port and no parity logic; all other behaviour is identical.

Test Plan:
- Bench structure: DUT sel2/sel1 drive an instance of the team's 4:1 mux, and mux `y` feeds y_in.
- DWELL=2, i=4'b0101 static, start pulse, ready=1 -> valid high exactly 8 edges after start; data_out=4'b0101; sel sequence 00,00,01,01,10,10,11,11 on consecutive cycles; back to IDLE, busy=0.
- DWELL=1, i=4'b1001, ready=0 -> valid at +4 edges; data_out=4'b1001 held for 10 cycles. Raise ready -> valid drops the next edge, busy=0.
- cont=1, ready=1, i=4'b1111 then changed to 4'b0010 during the second scan -> first word 4'b1111. Second word reflects per-channel sample timing: bits sampled after the change read 0010 values. Words are spaced 4*DWELL+1 edges.
- Pulse start at every edge during SCAN and HOLD -> exactly one word produced; no restart of sel sequence.
- Assert rst_n=0 mid-scan, after sel=10 -> all outputs at reset values immediately, without waiting for clk. A fresh start then yields a correct full word.
- With MUX_SCAN_PARITY_EN defined, i=4'b0111 -> data_out=4'b0111, parity_out=1. i=4'b0110 -> parity_out=0.
